// File: rtl/branch_history_table_pkg.sv
// Shared types and the saturating-counter helper for the branch history table.
package branch_history_table_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic        taken;
    } bht_update_t;

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] cnt;
    } bht_entry_t;

    typedef enum logic {
        INIT,
        RUN
    } bht_state_e;

    // 2-bit saturating up/down counter step.
    function automatic logic [1:0] sat_inc_dec(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == 2'b11) ? 2'b11 : cnt + 2'd1;
        end else begin
            res = (cnt == 2'b00) ? 2'b00 : cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// Direction predictor: one 2-bit saturating counter per entry, cleared by a
// one-entry-per-cycle sweep after reset or flush, trained by resolved branches.
module branch_history_table
    import branch_history_table_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 1024
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            debug_mode_i,
    input  logic [63:0]     vpc_i,
    input  bht_update_t     bht_update_i,
    output bht_prediction_t bht_prediction_o,
    output logic            busy_o
);

    localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

    bht_state_e state_reg, state_next;
    logic [IDX_W-1:0] sweep_cnt_reg, sweep_cnt_next;

    bht_entry_t entries [NR_ENTRIES];

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    bht_entry_t       wr_data;

    logic [IDX_W-1:0] look_idx;
    logic [IDX_W-1:0] upd_idx;
    bht_entry_t       look_entry;
    bht_entry_t       upd_entry;

    // Bit 0 is dropped so that compressed (2-byte aligned) PCs get their own entry.
    assign look_idx   = vpc_i[IDX_W:1];
    assign upd_idx    = bht_update_i.pc[IDX_W:1];
    assign look_entry = entries[look_idx];
    assign upd_entry  = entries[upd_idx];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{vpc_i[63:IDX_W+1], vpc_i[0],
                              bht_update_i.pc[63:IDX_W+1], bht_update_i.pc[0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= INIT;
            sweep_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sweep_cnt_reg <= sweep_cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        sweep_cnt_next   = sweep_cnt_reg;
        wr_en            = 1'b0;
        wr_idx           = sweep_cnt_reg;
        wr_data          = '0;
        busy_o           = 1'b0;
        bht_prediction_o = '0;

        case (state_reg)
            INIT: begin
                busy_o = 1'b1;
                wr_en  = 1'b1;
                if (flush_i) begin
                    sweep_cnt_next = '0;
                end else if (sweep_cnt_reg == IDX_W'(NR_ENTRIES - 1)) begin
                    sweep_cnt_next = '0;
                    state_next     = RUN;
                end else begin
                    sweep_cnt_next = sweep_cnt_reg + 1'b1;
                end
            end
            RUN: begin
                // Read is taken before any same-cycle write lands: no bypass.
                bht_prediction_o.valid = look_entry.valid;
                bht_prediction_o.taken = look_entry.valid & look_entry.cnt[1];
                if (flush_i) begin
                    state_next     = INIT;
                    sweep_cnt_next = '0;
                end else if (bht_update_i.valid && !debug_mode_i) begin
                    wr_en         = 1'b1;
                    wr_idx        = upd_idx;
                    wr_data.valid = 1'b1;
                    if (!upd_entry.valid) begin
                        wr_data.cnt = bht_update_i.taken ? 2'b10 : 2'b01;
                    end else begin
                        wr_data.cnt = sat_inc_dec(upd_entry.cnt, bht_update_i.taken);
                    end
                end
            end
            default: begin
                state_next     = INIT;
                sweep_cnt_next = '0;
            end
        endcase
    end

    // Storage has no reset; the sweep establishes its contents.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            entries[wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table with a behavioural counter model.
module tb_branch_history_table;
    import branch_history_table_pkg::*;

    localparam int N = 16;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic            debug_mode_i;
    logic [63:0]     vpc_i;
    bht_update_t     bht_update_i;
    bht_prediction_t bht_prediction_o;
    logic            busy_o;

    branch_history_table #(.NR_ENTRIES(N)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .debug_mode_i     (debug_mode_i),
        .vpc_i            (vpc_i),
        .bht_update_i     (bht_update_i),
        .bht_prediction_o (bht_prediction_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: validity flag and counter value 0..3 per entry.
    bit mvalid [N];
    int mcnt   [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int idx_of(input logic [63:0] pc);
        return int'((pc >> 1) % N);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mvalid[i] = 1'b0;
            mcnt[i]   = 0;
        end
    endtask

    task automatic model_update(input logic [63:0] pc, input logic taken);
        int i;
        i = idx_of(pc);
        if (!mvalid[i]) begin
            mvalid[i] = 1'b1;
            mcnt[i]   = taken ? 2 : 1;
        end else if (taken) begin
            mcnt[i] = (mcnt[i] + 1 > 3) ? 3 : mcnt[i] + 1;
        end else begin
            mcnt[i] = (mcnt[i] - 1 < 0) ? 0 : mcnt[i] - 1;
        end
    endtask

    function automatic logic [1:0] exp_pred(input logic [63:0] pc);
        int i;
        i = idx_of(pc);
        return {mvalid[i], mvalid[i] && (mcnt[i] >= 2)};
    endfunction

    // One RUN-state transaction: drive after negedge, check the pre-update
    // lookup, then advance the model across the clock edge.
    task automatic do_cycle(input string tag, input logic [63:0] lpc, input logic uv,
                            input logic [63:0] upc, input logic ut, input logic dbg,
                            input logic fl);
        logic [1:0] exp;
        vpc_i        = lpc;
        bht_update_i = '{valid: uv, pc: upc, taken: ut};
        debug_mode_i = dbg;
        flush_i      = fl;
        #1;
        exp = exp_pred(lpc);
        $display("%-14s look=%h upd=%0b/%h/%0b dbg=%0b fl=%0b pred=%0b%0b exp=%0b",
                 tag, lpc, uv, upc, ut, dbg, fl,
                 bht_prediction_o.valid, bht_prediction_o.taken, exp);
        check({tag, "_pred"}, 64'(bht_prediction_o), 64'(exp));
        @(posedge clk_i);
        if (fl) model_clear();
        else if (uv && !dbg) model_update(upc, ut);
        @(negedge clk_i);
        bht_update_i.valid = 1'b0;
        debug_mode_i       = 1'b0;
        flush_i            = 1'b0;
    endtask

    // Count clock edges until busy_o drops; predictions must read '0 throughout.
    // Optionally injects an update to index 0 mid-sweep, which must be ignored.
    task automatic wait_sweep(input string tag, input int exp_cycles, input bit inject);
        int c;
        c = 0;
        check({tag, "_busy_start"}, 64'(busy_o), 64'(1));
        while (busy_o === 1'b1 && c < 100) begin
            check({tag, "_init_pred"}, 64'(bht_prediction_o), 64'(0));
            vpc_i = {$urandom(), $urandom()};
            if (inject && c == 10) bht_update_i = '{valid: 1'b1, pc: 64'h0, taken: 1'b1};
            if (inject && c == 11) bht_update_i.valid = 1'b0;
            @(posedge clk_i);
            #1;
            c++;
        end
        bht_update_i.valid = 1'b0;
        $display("%-14s sweep cycles=%0d exp=%0d", tag, c, exp_cycles);
        check({tag, "_cycles"}, 64'(c), 64'(exp_cycles));
        @(negedge clk_i);
    endtask

    task automatic scan_all(input string tag);
        for (int p = 0; p <= 'h1E; p += 2) begin
            do_cycle(tag, 64'(p), 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst_ni       = 1'b0;
        flush_i      = 1'b0;
        debug_mode_i = 1'b0;
        vpc_i        = '0;
        bht_update_i = '0;
        model_clear();

        // Reset and the initial sweep
        repeat (3) @(negedge clk_i);
        check("reset_pred", 64'(bht_prediction_o), 64'(0));
        check("reset_busy", 64'(busy_o), 64'(1));
        rst_ni = 1'b1;
        wait_sweep("reset_init", 16, 1'b0);
        scan_all("post_reset");

        // Training and saturation
        repeat (3) do_cycle("train_t", 64'h8000_0010, 1'b1, 64'h8000_0010, 1'b1, 1'b0, 1'b0);
        do_cycle("look_sat", 64'h8000_0010, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) do_cycle("train_nt", 64'h8000_0010, 1'b1, 64'h8000_0010, 1'b0, 1'b0, 1'b0);
        do_cycle("look_wk", 64'h8000_0010, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

        // Compressed indexing and aliasing
        do_cycle("upd_c", 64'h0, 1'b1, 64'h2, 1'b1, 1'b0, 1'b0);
        do_cycle("look_2", 64'h2, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        do_cycle("look_0", 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        do_cycle("look_4", 64'h4, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        do_cycle("look_22", 64'h22, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

        // Debug gating and same-cycle lookup/update
        do_cycle("dbg_upd", 64'h2, 1'b1, 64'h22, 1'b0, 1'b1, 1'b0);
        do_cycle("dbg_look", 64'h2, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        do_cycle("same_cyc", 64'h2, 1'b1, 64'h2, 1'b0, 1'b0, 1'b0);
        do_cycle("next_cyc", 64'h2, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

        // Flush in RUN with an update in the same cycle
        do_cycle("flush_upd", 64'h8000_0010, 1'b1, 64'h4, 1'b1, 1'b0, 1'b1);
        vpc_i = 64'h8000_0010;
        #1;
        check("flush_init_pred", 64'(bht_prediction_o), 64'(0));
        wait_sweep("flush_sweep", 16, 1'b1);
        scan_all("post_flush");

        // Flush again at sweep 7
        do_cycle("train_b", 64'h6, 1'b1, 64'h6, 1'b1, 1'b0, 1'b0);
        do_cycle("flush_b", 64'h6, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        repeat (7) @(posedge clk_i);
        @(negedge clk_i);
        check("flush7_busy", 64'(busy_o), 64'(1));
        flush_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b0;
        wait_sweep("flush7_sweep", 16, 1'b0);
        scan_all("post_flush7");

        // Asynchronous reset during training
        do_cycle("train_c", 64'h6, 1'b1, 64'h6, 1'b1, 1'b0, 1'b0);
        vpc_i        = 64'h6;
        bht_update_i = '{valid: 1'b1, pc: 64'h6, taken: 1'b1};
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_upd_pred", 64'(bht_prediction_o), 64'(0));
        check("rst_upd_busy", 64'(busy_o), 64'(1));
        bht_update_i.valid = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_clear();
        wait_sweep("rst_upd_sweep", 16, 1'b0);
        scan_all("post_rst_upd");

        // Asynchronous reset at sweep 9
        do_cycle("train_d", 64'h1E, 1'b1, 64'h1E, 1'b1, 1'b0, 1'b0);
        do_cycle("flush_d", 64'h1E, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        repeat (9) @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_sweep_pred", 64'(bht_prediction_o), 64'(0));
        check("rst_sweep_busy", 64'(busy_o), 64'(1));
        @(negedge clk_i);
        rst_ni = 1'b1;
        wait_sweep("rst_sweep9", 16, 1'b0);
        scan_all("post_rst9");

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic fl;
            fl = ($urandom_range(0, 79) == 0);
            do_cycle("rand", {$urandom(), $urandom()}, 1'($urandom_range(0, 3) != 0),
                     {$urandom(), $urandom()}, 1'($urandom()),
                     1'($urandom_range(0, 5) == 0), fl);
            if (fl) wait_sweep("rand_flush", 16, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
